matrix_row_scan: RTL and testbench

- Downstream consumer of the sys_clk-domain blink/tick logic in the LED-matrix design.
- Time-multiplexes a ROWS x COLS LED matrix: one row lit at a time, with an inter-row blanking gap to prevent ghosting.
- Pixels come from a double-buffered frame store; a host writes the back buffer and requests a swap, which is applied only at a frame boundary.

---
 rtl/matrix_pkg.sv | 19 +
 rtl/row_timer.sv | 75 +++++++
 rtl/matrix_row_scan.sv | 108 ++++++++++
 tb/tb_matrix_row_scan.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and defaults for the LED-matrix row scanner.
// Holds the scan state encoding and the default geometry and timing.
package matrix_pkg;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_TICK_DIV     = 600;
  localparam int DEF_BLANK_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  typedef logic [DEF_ROWS-1:0] row_t;
  typedef logic [DEF_COLS-1:0] pix_t;

endpackage

// File: rtl/row_timer.sv
// Row prescaler for the matrix scanner: divides sys_clk into row periods,
// steps the row index and reports blank/show phase and the frame wrap.
module row_timer
  import matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int DW = $clog2(TICK_DIV + 1),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output scan_state_e   state_o,
  output logic [RW-1:0] row_idx_o,
  output logic          show_o,
  output logic          wrap_o
);

  localparam logic [DW-1:0] TICK_W  = DW'(TICK_DIV);
  localparam logic [DW-1:0] BLANK_W = DW'(BLANK_CYCLES);
  localparam logic [RW-1:0] LAST_W  = RW'(ROWS - 1);

  scan_state_e   state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          row_end;
  logic          last_row;

  assign row_end  = (div_cnt_q == TICK_W);
  assign last_row = (row_idx_q == LAST_W);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    row_idx_d = row_idx_q;
    if (!en) begin
      state_d   = ST_IDLE;
      div_cnt_d = '0;
      row_idx_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d   = ST_BLANK;
      div_cnt_d = '0;
      row_idx_d = '0;
    end else begin
      if (row_end) begin
        div_cnt_d = '0;
        row_idx_d = last_row ? '0 : row_idx_q + RW'(1);
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
      // Phase is a pure function of the prescaler position within the row.
      state_d = (div_cnt_d < BLANK_W) ? ST_BLANK : ST_SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      row_idx_q <= row_idx_d;
    end
  end

  assign state_o   = state_q;
  assign row_idx_o = row_idx_q;
  assign show_o    = en && (state_q == ST_SHOW);
  assign wrap_o    = en && (state_q != ST_IDLE) && row_end && last_row;

endmodule

// File: rtl/matrix_row_scan.sv
// Time-multiplexed LED-matrix driver: double-buffered frame store, swap at
// frame boundary, one row lit per period with a leading blanking gap.
module matrix_row_scan
  import matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int RW = $clog2(ROWS),
  // Write address is wide enough to express ROWS itself, so out-of-range
  // addresses are rejected rather than aliased onto a real row.
  localparam int AW = $clog2(ROWS + 1)
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_done,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_start
);

  scan_state_e   tmr_state;
  logic [RW-1:0] row_idx;
  logic          show;
  logic          wrap;

  row_timer #(
    .ROWS        (ROWS),
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_row_timer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .en       (en),
    .state_o  (tmr_state),
    .row_idx_o(row_idx),
    .show_o   (show),
    .wrap_o   (wrap)
  );

  logic [1:0][ROWS-1:0][COLS-1:0] fb_q, fb_d;
  logic                           front_q, front_d;
  logic                           swap_pending_q, swap_pending_d;
  logic                           swap_done_q, swap_done_d;
  logic                           frame_start_q, frame_start_d;
  logic [ROWS-1:0]                row_sel_q, row_sel_d;
  logic [COLS-1:0]                col_data_q, col_data_d;
  logic                           idle;
  logic                           swap_apply;

  assign idle = (tmr_state == ST_IDLE);

  // swap_req and wr_en are single-cycle strobes sampled on every posedge;
  // there is no backpressure. A request made on the wrap edge itself waits
  // for the following frame end.
  assign swap_apply = swap_pending_q && (idle || wrap);

  always_comb begin
    fb_d           = fb_q;
    front_d        = front_q ^ swap_apply;
    swap_pending_d = swap_apply ? swap_req : (swap_pending_q | swap_req);
    swap_done_d    = swap_apply;
    frame_start_d  = en && (idle || wrap);
    row_sel_d      = '0;
    col_data_d     = '0;
    // Indexed by the pre-swap front, so a write coinciding with a swap
    // lands in the bank that is about to be displayed.
    if (wr_en && (wr_row < AW'(ROWS))) begin
      fb_d[!front_q][wr_row[RW-1:0]] = wr_data;
    end
    if (show) begin
      row_sel_d  = ROWS'(1) << row_idx;
      col_data_d = fb_q[front_q][row_idx];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fb_q           <= '0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      row_sel_q      <= '0;
      col_data_q     <= '0;
    end else begin
      fb_q           <= fb_d;
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      frame_start_q  <= frame_start_d;
      row_sel_q      <= row_sel_d;
      col_data_q     <= col_data_d;
    end
  end

  assign swap_done   = swap_done_q;
  assign frame_start = frame_start_q;
  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;

endmodule

// File: tb/tb_matrix_row_scan.sv
// Bench for matrix_row_scan: time-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_matrix_row_scan;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int TICK_DIV = 9;
  localparam int BLANK    = 2;
  localparam int PERIOD   = TICK_DIV + 1;
  localparam int FRAME    = PERIOD * ROWS;
  localparam int AW       = $clog2(ROWS + 1);

  // ---------------- clock / reset / DUT ----------------
  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            en = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            swap_req = 1'b0;
  logic            swap_done;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;

  always #5 sys_clk = ~sys_clk;

  matrix_row_scan #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_start(frame_start)
  );

  int checks   = 0;
  int failures = 0;
  int model_prints = 0;

  // ---------------- reference model ----------------
  // m_t counts clock edges since the scan started (-1 = not scanning);
  // row and phase follow by plain division of elapsed time.
  int              m_t;
  logic            m_front;
  logic            m_pend;
  logic [COLS-1:0] m_buf [2][ROWS];
  logic [ROWS-1:0] exp_row_sel;
  logic [COLS-1:0] exp_col;
  logic            exp_done;
  logic            exp_fs;

  logic m_running, m_wrap, m_apply, m_lit;
  int   m_row, m_phase;

  assign m_running = (m_t >= 0);
  assign m_row     = m_running ? (m_t / PERIOD) % ROWS : 0;
  assign m_phase   = m_running ? (m_t % PERIOD) : 0;
  assign m_wrap    = m_running && en && ((m_t % FRAME) == FRAME - 1);
  assign m_apply   = m_pend && (!m_running || m_wrap);
  assign m_lit     = m_running && en && (m_phase >= BLANK);

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_t         <= -1;
      m_front     <= 1'b0;
      m_pend      <= 1'b0;
      exp_row_sel <= '0;
      exp_col     <= '0;
      exp_done    <= 1'b0;
      exp_fs      <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++) m_buf[b][r] <= '0;
    end else begin
      exp_row_sel <= m_lit ? ROWS'(1 << m_row) : '0;
      exp_col     <= m_lit ? m_buf[m_front][m_row] : '0;
      exp_fs      <= en && (!m_running || m_wrap);
      exp_done    <= m_apply;
      if (wr_en && (int'(wr_row) < ROWS)) m_buf[!m_front][wr_row[1:0]] <= wr_data;
      m_front <= m_front ^ m_apply;
      m_pend  <= m_apply ? swap_req : (m_pend | swap_req);
      m_t     <= !en ? -1 : (m_running ? m_t + 1 : 0);
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      checks++;
      if ({row_sel, col_data, swap_done, frame_start} !==
          {exp_row_sel, exp_col, exp_done, exp_fs}) begin
        failures++;
        if (model_prints < 10) begin
          model_prints++;
          $display("FAIL model_cycle t=%0t: got row_sel=%b col=%h done=%b fs=%b, expected row_sel=%b col=%h done=%b fs=%b",
                   $time, row_sel, col_data, swap_done, frame_start,
                   exp_row_sel, exp_col, exp_done, exp_fs);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_row(input logic [AW-1:0] r, input logic [COLS-1:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
  endtask

  // Lands on the sample where frame_start is high (frame position 1).
  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    check(name, frame_start, 1);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (swap_done === 1'b1) c++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c;

    // Reset, then idle with en=0.
    step(3);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_outputs", {row_sel, col_data, swap_done, frame_start}, 0);
    end

    // Basic scan: fill back buffer, swap in IDLE, enable.
    write_row(0, 4'h1);
    write_row(1, 4'h2);
    write_row(2, 4'h4);
    write_row(3, 4'h8);
    pulse_swap();
    step(1);
    check("idle_swap_done", swap_done, 1);
    en = 1'b1;
    for (int k = 1; k <= FRAME + 1; k++) begin
      step(1);
      case (k)
        1:  begin check("start_fs", frame_start, 1); check("start_dark", row_sel, 0); end
        3:  check("blank_dark", row_sel, 0);
        4:  begin check("row0_first_sel", row_sel, 4'b0001); check("row0_col", col_data, 4'h1); end
        11: check("row0_last_sel", row_sel, 4'b0001);
        12: check("row1_blank", {row_sel, col_data}, 0);
        14: begin check("row1_sel", row_sel, 4'b0010); check("row1_col", col_data, 4'h2); end
        24: check("row2_col", col_data, 4'h4);
        34: check("row3_col", col_data, 4'h8);
        FRAME + 1: check("frame_period_fs", frame_start, 1);
        default: ;
      endcase
    end

    // Swap mid-frame: display unchanged until the wrap.
    step(15);
    write_row(0, 4'hF);
    pulse_swap();
    c = 0;
    for (int s = 19; s <= FRAME; s++) begin
      step(1);
      if (swap_done === 1'b1) c++;
      if (s == 35) check("pre_swap_row3_col", col_data, 4'h8);
    end
    check("no_early_swap_done", c, 0);
    step(1);
    check("wrap_swap_done", swap_done, 1);
    check("wrap_lag_col_old", col_data, 4'h8);
    step(3);
    check("post_swap_row0_col", col_data, 4'hF);
    step(10);
    check("post_swap_row1_col", col_data, 4'h0);

    // Three requests inside one frame collapse into a single swap.
    pulse_swap();
    step(4);
    pulse_swap();
    step(4);
    pulse_swap();
    count_done(2 * FRAME, c);
    check("triple_swap_once", c, 1);
    wait_fs("fs_after_triple");
    step(3);
    check("triple_row0_col", col_data, 4'h1);

    // Request exactly on the wrap edge: applied one frame later.
    wait_fs("fs_before_boundary");
    step(FRAME - 1);
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
    check("boundary_fs", frame_start, 1);
    check("boundary_no_done", swap_done, 0);
    count_done(FRAME - 1, c);
    check("boundary_quiet_frame", c, 0);
    step(1);
    check("boundary_done_next_frame", swap_done, 1);
    step(3);
    check("boundary_row0_col", col_data, 4'hF);

    // Enable drop during row 2 SHOW, then restart.
    wait_fs("fs_before_drop");
    step(23);
    check("row2_show_sel", row_sel, 4'b0100);
    en = 1'b0;
    step(1);
    check("drop_dark", {row_sel, col_data, frame_start}, 0);
    step(5);
    en = 1'b1;
    step(1);
    check("restart_fs", frame_start, 1);
    step(2);
    check("restart_blank", row_sel, 0);
    step(1);
    check("restart_row0_sel", row_sel, 4'b0001);
    check("restart_row0_col", col_data, 4'hF);

    // Out-of-range write must not alias onto row 0.
    en = 1'b0;
    step(2);
    write_row(0, 4'h3);
    write_row(1, 4'h5);
    write_row(2, 4'h6);
    write_row(3, 4'h9);
    write_row(3'd4, 4'hF);
    pulse_swap();
    step(1);
    check("oor_swap_done", swap_done, 1);
    en = 1'b1;
    step(4);
    check("oor_row0_col", col_data, 4'h3);
    step(10);
    check("oor_row1_col", col_data, 4'h5);
    step(10);
    check("oor_row2_col", col_data, 4'h6);
    step(10);
    check("oor_row3_col", col_data, 4'h9);

    // Reset mid-SHOW clears outputs at once and drops the pending swap.
    pulse_swap();
    check("pre_reset_sel", row_sel, 4'b1000);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset_sel", row_sel, 0);
    check("async_reset_col", col_data, 0);
    en = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    count_done(6, c);
    check("pending_lost", c, 0);
    check("post_reset_dark", {row_sel, col_data, frame_start}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
